lcd_nibble_receiver: RTL and testbench

//  LCD-side responder for the 4-bit HD44780-style bus the MiniAlu drives (oLCD/oEnable/oRegisterSelect/oReadWrite).

---
 rtl/lcd_nibble_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_lcd_nibble_receiver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_receiver.sv
// LCD-side responder for a 4-bit HD44780-style bus: pairs E-falling-edge nibbles into bytes,
// runs a small command subset and keeps a character buffer with a registered read port.
module lcd_nibble_receiver #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [3:0]        iLCD,
  input  logic              iEnable,
  input  logic              iRegisterSelect,
  input  logic              iReadWrite,
  input  logic [ADDR_W-1:0] iReadAddress,
  output logic [7:0]        oReadChar,
  output logic              oByteValid,
  output logic [7:0]        oByte,
  output logic              oIsData,
  output logic [ADDR_W-1:0] oAddress,
  output logic              oFourBitMode,
  output logic              oBusy,
  output logic              oProtocolError
);

  typedef enum logic [1:0] {S_INIT, S_HIGH, S_LOW} state_t;

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic [3:0]        lcd_q, lcd_d;
  logic              rs_q, rs_d;
  logic              rw_q, rw_d;
  logic [3:0]        hi_q, hi_d;
  logic              hi_rs_q, hi_rs_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_q, byte_d;
  logic              is_data_q, is_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              incr_q, incr_d;
  logic              four_q, four_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              strobe;
  logic [7:0]        asm_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        read_char_q;

  // Captured fields come from the last cycle E was high, so a 1-cycle E pulse is enough.
  assign strobe   = en_q & ~iEnable;
  assign asm_byte = {hi_q, lcd_q};

  always_comb begin
    state_d      = state_q;
    en_d         = iEnable;
    lcd_d        = iLCD;
    rs_d         = iRegisterSelect;
    rw_d         = iReadWrite;
    hi_d         = hi_q;
    hi_rs_d      = hi_rs_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    is_data_d    = is_data_q;
    addr_d       = addr_q;
    incr_d       = incr_q;
    four_d       = four_q;
    busy_d       = busy_q;
    err_d        = err_q;
    clr_cnt_d    = clr_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = addr_q;
    mem_wdata    = asm_byte;

    if (busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = 8'h20;
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST_ENTRY) begin
        busy_d = 1'b0;
        addr_d = '0;
        incr_d = 1'b1;
      end
    end

    if (strobe) begin
      if (rw_q || busy_q) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          S_INIT: begin
            if (rs_q) begin
              err_d = 1'b1;
            end else if (lcd_q == 4'h2) begin
              state_d = S_HIGH;
              four_d  = 1'b1;
            end
          end
          S_HIGH: begin
            hi_d    = lcd_q;
            hi_rs_d = rs_q;
            state_d = S_LOW;
          end
          S_LOW: begin
            state_d = S_HIGH;
            if (rs_q != hi_rs_q) begin
              err_d = 1'b1;
            end else begin
              byte_valid_d = 1'b1;
              byte_d       = asm_byte;
              is_data_d    = rs_q;
              if (rs_q) begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = asm_byte;
                addr_d    = incr_q ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
              end else begin
                // First match from the MSB wins, as on the real controller.
                casez (asm_byte)
                  8'b1???_????: addr_d = asm_byte[ADDR_W-1:0];
                  8'b001?_????: ;
                  8'b0000_01??: incr_d = asm_byte[1];
                  8'b0000_001?: addr_d = '0;
                  8'b0000_0001: begin
                    busy_d    = 1'b1;
                    clr_cnt_d = '0;
                  end
                  default: ;
                endcase
              end
            end
          end
          default: state_d = S_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_INIT;
      en_q         <= 1'b0;
      lcd_q        <= '0;
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      hi_q         <= '0;
      hi_rs_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      is_data_q    <= 1'b0;
      addr_q       <= '0;
      incr_q       <= 1'b1;
      four_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      clr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      lcd_q        <= lcd_d;
      rs_q         <= rs_d;
      rw_q         <= rw_d;
      hi_q         <= hi_d;
      hi_rs_q      <= hi_rs_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      is_data_q    <= is_data_d;
      addr_q       <= addr_d;
      incr_q       <= incr_d;
      four_q       <= four_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  // Buffer contents survive Reset; only the write enable is suppressed during it.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      read_char_q <= '0;
    end else begin
      read_char_q <= mem[iReadAddress];
    end
  end

  assign oReadChar      = read_char_q;
  assign oByteValid     = byte_valid_q;
  assign oByte          = byte_q;
  assign oIsData        = is_data_q;
  assign oAddress       = addr_q;
  assign oFourBitMode   = four_q;
  assign oBusy          = busy_q;
  assign oProtocolError = err_q;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Randomized bench for lcd_nibble_receiver: drives nibble strobes and checks every strobe
// against a behavioural LCD model (flags, address counter, character buffer).
module tb_lcd_nibble_receiver;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] iLCD = '0;
  logic       iEnable = 1'b0;
  logic       iRegisterSelect = 1'b0;
  logic       iReadWrite = 1'b0;
  logic [4:0] iReadAddress = '0;
  logic [7:0] oReadChar;
  logic       oByteValid;
  logic [7:0] oByte;
  logic       oIsData;
  logic [4:0] oAddress;
  logic       oFourBitMode;
  logic       oBusy;
  logic       oProtocolError;

  lcd_nibble_receiver #(.DEPTH(32), .ADDR_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .iLCD(iLCD), .iEnable(iEnable),
    .iRegisterSelect(iRegisterSelect), .iReadWrite(iReadWrite),
    .iReadAddress(iReadAddress), .oReadChar(oReadChar), .oByteValid(oByteValid),
    .oByte(oByte), .oIsData(oIsData), .oAddress(oAddress), .oFourBitMode(oFourBitMode),
    .oBusy(oBusy), .oProtocolError(oProtocolError)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_cycles = 0;

  // Behavioural model state
  logic [7:0] m_mem [32];
  bit         m_known [32];
  bit         m_four, m_have_hi, m_hi_rs, m_incr, m_err, m_last_rs, m_valid;
  logic [3:0] m_hi;
  logic [7:0] m_last_byte;
  int         m_addr;
  int         m_busy_end;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    if (oBusy) busy_cycles++;
  endtask

  task automatic model_reset();
    m_four = 0; m_have_hi = 0; m_hi_rs = 0; m_incr = 1; m_err = 0;
    m_last_rs = 0; m_last_byte = 8'h00; m_addr = 0; m_busy_end = 0; m_hi = 4'h0;
  endtask

  task automatic model_execute(input logic [7:0] b, input bit rs, input int scyc);
    if (rs) begin
      m_mem[m_addr] = b;
      m_known[m_addr] = 1;
      m_addr = (m_addr + (m_incr ? 1 : 31)) % 32;
    end else if (b >= 8'h80) begin
      m_addr = b % 32;
    end else if (b >= 8'h20) begin
      // function set or CGRAM address: no visible effect
    end else if (b >= 8'h04 && b <= 8'h07) begin
      m_incr = b[1];
    end else if (b == 8'h02 || b == 8'h03) begin
      m_addr = 0;
    end else if (b == 8'h01) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 8'h20;
        m_known[i] = 1;
      end
      m_addr = 0;
      m_incr = 1;
      m_busy_end = scyc + 32;
    end
  endtask

  task automatic model_strobe(input logic [3:0] n, input bit rs, input bit rw, input int scyc);
    bit busy;
    busy = (scyc <= m_busy_end);
    m_valid = 0;
    if (rw || busy) begin
      m_err = 1;
    end else if (!m_four) begin
      if (rs) m_err = 1;
      else if (n == 4'h2) m_four = 1;
    end else if (!m_have_hi) begin
      m_hi = n; m_hi_rs = rs; m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      if (rs != m_hi_rs) begin
        m_err = 1;
      end else begin
        m_valid = 1;
        m_last_byte = {m_hi, n};
        m_last_rs = rs;
        model_execute({m_hi, n}, rs, scyc);
      end
    end
  endtask

  task automatic send_nibble(input logic [3:0] n, input bit rs, input bit rw);
    int hold;
    hold = $urandom_range(1, 3);
    iLCD = n; iRegisterSelect = rs; iReadWrite = rw; iEnable = 1'b1;
    repeat (hold) tick();
    iEnable = 1'b0;
    tick();
    model_strobe(n, rs, rw, cyc);
    check("byte_valid", oByteValid, m_valid);
    check("byte", oByte, m_last_byte);
    check("is_data", oIsData, m_last_rs);
    check("proto_err", oProtocolError, m_err);
    check("four_bit", oFourBitMode, m_four);
    if (cyc > m_busy_end) check("address", oAddress, m_addr);
    $display("nibble %h rs=%0b rw=%0b hold=%0d -> valid=%0b byte=%h addr=%0d err=%0b",
             n, rs, rw, hold, oByteValid, oByte, oAddress, oProtocolError);
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rs);
    send_nibble(b[7:4], rs, 1'b0);
    send_nibble(b[3:0], rs, 1'b0);
  endtask

  task automatic read_check(input int a);
    iReadAddress = a[4:0];
    tick();
    if (m_known[a]) begin
      check("read_char", oReadChar, m_mem[a]);
      $display("read [%0d] = %h", a, oReadChar);
    end
  endtask

  task automatic do_reset();
    iEnable = 1'b0;
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    model_reset();
    check("rst_valid", oByteValid, 0);
    check("rst_byte", oByte, 0);
    check("rst_is_data", oIsData, 0);
    check("rst_addr", oAddress, 0);
    check("rst_four", oFourBitMode, 0);
    check("rst_busy", oBusy, 0);
    check("rst_err", oProtocolError, 0);
    check("rst_read_char", oReadChar, 0);
    $display("reset applied at cycle %0d", cyc);
  endtask

  task automatic init_seq();
    send_nibble(4'h3, 0, 0);
    send_nibble(4'h3, 0, 0);
    send_nibble(4'h3, 0, 0);
    send_nibble(4'h2, 0, 0);
  endtask

  task automatic wait_clear_done();
    int guard;
    guard = 0;
    while (oBusy && guard < 100) begin
      tick();
      guard++;
    end
    check("clear_timeout", oBusy, 0);
  endtask

  initial begin
    int b0;
    for (int i = 0; i < 32; i++) m_known[i] = 0;
    model_reset();

    // 1: reset and init sequence
    do_reset();
    init_seq();

    // 2: first data byte
    send_byte(8'h41, 1);
    read_check(0);

    // 3: set address, writes across the line boundary, wrap
    send_byte(8'h8F, 0);
    send_byte(8'h42, 1);
    send_byte(8'h43, 1);
    read_check(15);
    read_check(16);
    send_byte(8'h9F, 0);
    send_byte(8'h44, 1);
    read_check(31);

    // 4: decrement mode, write at 0 then wrap to 31
    send_byte(8'h04, 0);
    send_byte(8'h80, 0);
    send_byte(8'h5A, 1);
    read_check(0);

    // 5: clear, strobe while busy, exact busy length
    b0 = busy_cycles;
    send_byte(8'h01, 0);
    send_nibble(4'h4, 1, 0);
    wait_clear_done();
    check("busy_len", busy_cycles - b0, 32);
    tick();
    check("clear_addr", oAddress, 0);
    for (int a = 0; a < 32; a++) read_check(a);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        send_byte(8'($urandom_range(32, 126)), 1);
      end else if (op <= 6) begin
        int k;
        logic [7:0] c;
        k = $urandom_range(0, 5);
        case (k)
          0: c = 8'h80 | 8'($urandom_range(0, 127));
          1: c = 8'h04 | 8'($urandom_range(0, 3));
          2: c = 8'h02 | 8'($urandom_range(0, 1));
          3: c = 8'($urandom_range(8, 31));
          4: c = 8'h20 | 8'($urandom_range(0, 95));
          default: c = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h0C;
        endcase
        send_byte(c, 0);
        if (c == 8'h01) begin
          wait_clear_done();
          tick();
        end
      end else if (op == 7) begin
        send_nibble(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);
      end else if (op == 8) begin
        bit r;
        r = 1'($urandom_range(0, 1));
        send_nibble(4'($urandom_range(0, 15)), r, 0);
        send_nibble(4'($urandom_range(0, 15)), !r, 0);
      end else begin
        read_check($urandom_range(0, 31));
      end
    end

    // 6: RS mismatch within a byte, then reset mid-byte
    do_reset();
    init_seq();
    send_nibble(4'h4, 0, 0);
    send_nibble(4'h1, 1, 0);
    send_nibble(4'h4, 1, 0);
    do_reset();
    send_nibble(4'h4, 0, 0);
    send_nibble(4'h2, 0, 0);
    send_byte(8'h80, 0);
    send_byte(8'h61, 1);
    read_check(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
